// File: rtl/encoder_8_3_seq_if.sv
// Request/code bundle for the registered 8-to-3 priority encoder.
// The slave side is the encoder; the master side is the event source plus code consumer.
interface encoder_8_3_seq_if;
    logic [7:0] req;
    logic       out_ready;
    logic [2:0] out_code;
    logic       out_valid;
    logic [7:0] pending;
    logic       dropped;

    modport slave (
        input  req,
        input  out_ready,
        output out_code,
        output out_valid,
        output pending,
        output dropped
    );

    modport master (
        output req,
        output out_ready,
        input  out_code,
        input  out_valid,
        input  pending,
        input  dropped
    );
endinterface

// File: rtl/encoder_8_3_seq.sv
// Registered 8-to-3 priority encoder: accumulates posted request lines and hands out
// their indices one per valid/ready transfer, highest index first.
module encoder_8_3_seq (
    input  logic               clk,
    input  logic               rst,
    encoder_8_3_seq_if.slave   bus
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [7:0] pending_r;
    logic [7:0] pending_s;
    logic [2:0] out_code_r;
    logic [2:0] code_s;
    logic       dropped_r;
    logic       dropped_s;
    logic       load_s;
    logic [2:0] load_idx_s;
    logic [7:0] clr_s;

    // Index of the highest set bit; an all-zero vector is never loaded, so 0 is a safe fill.
    function automatic logic [2:0] top_index(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Next-state logic: a load refills the output whenever it is free or being consumed.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        case (state_r)
            EMPTY: begin
                if (|pending_r) begin
                    load_s  = 1'b1;
                    state_s = FULL;
                end else begin
                    state_s = EMPTY;
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    if (|pending_r) begin
                        load_s  = 1'b1;
                        state_s = FULL;
                    end else begin
                        state_s = EMPTY;
                    end
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = EMPTY;
            end
        endcase
    end

    // Datapath: pick the loaded bit, clear it, and merge new requests over the clear.
    always_comb begin
        load_idx_s = top_index(pending_r);
        if (load_s) begin
            clr_s  = 8'h01 << load_idx_s;
            code_s = load_idx_s;
        end else begin
            clr_s  = 8'h00;
            code_s = out_code_r;
        end
        // A re-post of the bit being loaded is not a collision: it survives as a new event.
        pending_s = (pending_r & ~clr_s) | bus.req;
        dropped_s = dropped_r | (|(bus.req & pending_r & ~clr_s));
    end

    // State, pending set, held code and sticky drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= EMPTY;
            pending_r  <= 8'h00;
            out_code_r <= 3'd0;
            dropped_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            pending_r  <= pending_s;
            out_code_r <= code_s;
            dropped_r  <= dropped_s;
        end
    end

    assign bus.out_valid = (state_r == FULL);
    assign bus.out_code  = out_code_r;
    assign bus.pending   = pending_r;
    assign bus.dropped   = dropped_r;

endmodule

// File: tb/tb_encoder_8_3_seq.sv
// Self-checking bench for encoder_8_3_seq: directed scenarios plus a code scoreboard
// filled when requests are driven and drained on every valid/ready transfer.
module tb_encoder_8_3_seq;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   exp_q[$];

    encoder_8_3_seq_if bus ();

    encoder_8_3_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs may change and outputs may be read afterwards.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        bus.req       = 8'h00;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        cyc();
        rst           = 1'b0;
    endtask

    // Scoreboard: every transfer must match the oldest expected code.
    always @(negedge clk) begin
        int exp_code;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_code", 32'(bus.out_code), 32'hFFFF_FFFF);
            end else begin
                exp_code = exp_q.pop_front();
                check("code_order", 32'(bus.out_code), 32'(exp_code));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.req       = 8'h00;
        bus.out_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        check("rst_pending", 32'(bus.pending), 32'h00);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_code", 32'(bus.out_code), 32'd0);
        check("rst_dropped", 32'(bus.dropped), 32'd0);

        // Fill everything, then reset asynchronously mid-cycle.
        bus.req = 8'hFF;
        cyc();
        cyc();
        check("fill_pending", 32'(bus.pending), 32'hFF);
        check("fill_valid", 32'(bus.out_valid), 32'd1);
        check("fill_code", 32'(bus.out_code), 32'd7);
        bus.req = 8'h00;
        rst = 1'b1;
        #1;
        check("arst_pending", 32'(bus.pending), 32'h00);
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_code", 32'(bus.out_code), 32'd0);
        check("arst_dropped", 32'(bus.dropped), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        check("post_rst_pending", 32'(bus.pending), 32'h00);

        // Single event, two-edge latency.
        bus.out_ready = 1'b1;
        bus.req = 8'h20;
        exp_q.push_back(5);
        cyc();
        bus.req = 8'h00;
        check("single_pend", 32'(bus.pending), 32'h20);
        check("single_early_valid", 32'(bus.out_valid), 32'd0);
        cyc();
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_code", 32'(bus.out_code), 32'd5);
        check("single_pend_clr", 32'(bus.pending), 32'h00);
        cyc();
        check("single_idle", 32'(bus.out_valid), 32'd0);

        // Multi-hot drain.
        bus.req = 8'h81;
        exp_q.push_back(7);
        exp_q.push_back(0);
        cyc();
        bus.req = 8'h00;
        cyc();
        check("multi_code7", 32'(bus.out_code), 32'd7);
        cyc();
        check("multi_code0", 32'(bus.out_code), 32'd0);
        check("multi_valid", 32'(bus.out_valid), 32'd1);
        cyc();
        check("multi_idle", 32'(bus.out_valid), 32'd0);

        // Backpressure holds the code and the remaining pending bit.
        bus.out_ready = 1'b0;
        bus.req = 8'h0C;
        exp_q.push_back(3);
        exp_q.push_back(2);
        cyc();
        bus.req = 8'h00;
        cyc();
        for (int i = 0; i < 5; i++) begin
            check("bp_code", 32'(bus.out_code), 32'd3);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_pending", 32'(bus.pending), 32'h04);
            cyc();
        end
        bus.out_ready = 1'b1;
        cyc();
        check("bp_code2", 32'(bus.out_code), 32'd2);
        cyc();
        check("bp_idle", 32'(bus.out_valid), 32'd0);

        // Preemption: a higher request never replaces the held code.
        bus.out_ready = 1'b0;
        bus.req = 8'h01;
        exp_q.push_back(0);
        cyc();
        bus.req = 8'h00;
        cyc();
        bus.req = 8'h80;
        exp_q.push_back(7);
        cyc();
        bus.req = 8'h00;
        check("pre_held", 32'(bus.out_code), 32'd0);
        check("pre_pending", 32'(bus.pending), 32'h80);
        bus.out_ready = 1'b1;
        cyc();
        check("pre_next", 32'(bus.out_code), 32'd7);
        cyc();
        check("pre_idle", 32'(bus.out_valid), 32'd0);

        // Eight simultaneous requests drain 7..0 back to back.
        bus.req = 8'hFF;
        for (int i = 7; i >= 0; i--) exp_q.push_back(i);
        cyc();
        bus.req = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            cyc();
            check("drain_valid", 32'(bus.out_valid), 32'd1);
            check("drain_code", 32'(bus.out_code), 32'(i));
        end
        cyc();
        check("drain_idle", 32'(bus.out_valid), 32'd0);

        // Duplicate post while pending and output busy on code 6.
        bus.out_ready = 1'b0;
        bus.req = 8'h50;
        exp_q.push_back(6);
        exp_q.push_back(4);
        cyc();
        bus.req = 8'h00;
        cyc();
        check("dup_code6", 32'(bus.out_code), 32'd6);
        check("dup_pending", 32'(bus.pending), 32'h10);
        check("dup_not_yet", 32'(bus.dropped), 32'd0);
        bus.req = 8'h10;
        cyc();
        bus.req = 8'h00;
        check("dup_dropped", 32'(bus.dropped), 32'd1);
        check("dup_pending2", 32'(bus.pending), 32'h10);
        bus.out_ready = 1'b1;
        cyc();
        check("dup_code4", 32'(bus.out_code), 32'd4);
        cyc();
        check("dup_idle", 32'(bus.out_valid), 32'd0);
        check("dup_sticky", 32'(bus.dropped), 32'd1);

        // Re-post on the load edge of the same bit is a new event, not a drop.
        pulse_reset();
        check("reset_clears_drop", 32'(bus.dropped), 32'd0);
        bus.out_ready = 1'b1;
        bus.req = 8'h08;
        exp_q.push_back(3);
        cyc();
        exp_q.push_back(3);
        cyc();
        bus.req = 8'h00;
        check("repost_code", 32'(bus.out_code), 32'd3);
        check("repost_pending", 32'(bus.pending), 32'h08);
        check("repost_dropped", 32'(bus.dropped), 32'd0);
        cyc();
        check("repost_code2", 32'(bus.out_code), 32'd3);
        check("repost_valid2", 32'(bus.out_valid), 32'd1);
        check("repost_pend_clr", 32'(bus.pending), 32'h00);
        cyc();
        check("repost_idle", 32'(bus.out_valid), 32'd0);
        check("repost_no_drop", 32'(bus.dropped), 32'd0);
        cyc();

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder_8_3_seq.md
# encoder_8_3_seq

Registered 8-to-3 priority encoder with a request-pending store and a valid/ready output handshake. It is the encoding counterpart of the 3-to-8 decoder: one-hot or multi-hot request lines come in, and 3-bit codes go out one at a time, highest index first. Every asserted request line is eventually reported exactly once. The block sits between scattered event sources and a single code consumer.

## Interface
- No parameters; widths are fixed at 8 requests and a 3-bit code.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request lines, sampled every rising edge. A 1 on bit i posts event i; level or pulse both allowed.
- out_ready  input  1  consumer accepts out_code this cycle.
- out_code  output  3  encoded index of the reported request.
- out_valid  output  1  out_code holds an unconsumed code.
- pending  output  8  registered set of posted, not-yet-reported requests.
- dropped  output  1  sticky flag: a request was posted while the same index was already pending.

## Operation
- Storage:
  - pending[7:0] register.
  - Output register {out_valid, out_code}.
  - dropped register.
- Priority: bit 7 is highest and bit 0 is lowest.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
- load condition: the output is EMPTY, or FULL with out_ready=1, and pending is nonzero.
- On load:
  - out_code becomes the index of the highest set bit of pending.
  - out_valid becomes 1.
  - That bit is cleared in pending on the same edge.
- Consume with nothing to load: FULL, out_ready=1, pending=0 → next state EMPTY, out_valid=0.
- FULL with out_ready=0: out_code and out_valid hold and pending is not cleared. Arriving requests still accumulate.
- EMPTY with pending=0: the block stays EMPTY.
- Pending update per edge: pending_next = (pending & ~clr) | req, where clr is the one-hot loaded bit (0 if no load).
  - req has priority over clr on the same bit, so a re-post of the bit being loaded stays pending and is not lost.
- dropped rules:
  - Sets when any bit i has req[i]=1, pending[i]=1, and clr[i]=0 on the same edge.
  - Once set, it stays set until reset.
  - The merged request is not counted twice.
- out_ready is ignored while EMPTY.
- Width rules: out_code is always 3 bits. Codes 0..7 map directly to indices and there is no invalid code. When out_valid=0, out_code holds its last value (0 after reset).

## Timing
- Reset (asynchronous, takes effect immediately): pending=8'h00, out_valid=0, out_code=3'd0, dropped=0.
- Latency: req[i] sampled at edge E sets pending[i] after E. The earliest out_valid=1 with out_code=i is after edge E+1.
  - Latency is therefore 2 edges from the request being present to the code being visible.
  - No combinational path from req to any output.
- Handshake:
  - A transfer occurs on an edge where out_valid=1 and out_ready=1.
  - Back-to-back transfers run at one code per cycle while pending is nonzero.
- Throughput: 8 simultaneous requests drain in 8 consecutive handshake cycles, in order 7,6,...,0.
- Preemption: a higher-priority request arriving while a lower code is FULL does not replace the held code. It is reported on the next load.
- Reset mid-operation: all pending events and any held code are discarded. After rst deasserts, the first edge behaves as EMPTY with pending=0.
- All outputs are registered and change only on a rising clk edge or on rst assertion.

## Test plan
- Reset: assert rst mid-cycle with pending=8'hFF and out_valid=1 → immediately pending=00, out_valid=0, out_code=0, dropped=0; stays idle after release with req=0.
- Single event: req=8'h20 for one cycle at edge E, out_ready=1 → out_valid=1, out_code=5 after E+1; pending=00; out_valid=0 after E+2.
- Multi-hot drain: req=8'h81 one cycle, out_ready=1 → out_code sequence 7 then 0 on consecutive cycles, then out_valid=0.
- Backpressure: req=8'h0C, out_ready=0 for 5 cycles → out_code=3 held and stable, pending=8'h04. Raise out_ready → codes 3 then 2.
- Duplicate/drop: req[4] posted, then req[4] again while pending[4]=1 and the output is busy on code 6 → dropped=1 and stays 1; code 4 is reported exactly once.
- Simultaneous re-post: re-assert req[3] on the same edge code 3 is loaded → pending[3] stays 1, dropped stays 0, code 3 is reported twice in total.
